// File: rtl/pu_io_req_router_pkg.sv
// Shared types and constants for the per-PU io request router: the io command
// layout, memory-select field position and downstream target indices.
package pu_io_req_router_pkg;

  localparam int unsigned PuWidthNbits     = 32;
  localparam int unsigned PuAddrNbits      = 16;
  localparam int unsigned PuTidNbits       = 4;
  localparam int unsigned PuMemSelMsb      = 15;
  localparam int unsigned PuMemSelLsb      = 13;
  localparam int unsigned PuNumOfTgt       = 4;
  localparam int unsigned PuIoTimeoutNbits = 8;

  localparam int unsigned TgtTopicMem   = 0;
  localparam int unsigned TgtTopicPdMem = 1;
  localparam int unsigned TgtFlowMem    = 2;
  localparam int unsigned TgtStatMem    = 3;

  typedef struct packed {
    logic [PuAddrNbits-1:0]  addr;
    logic [PuTidNbits-1:0]   tid;
    logic                    wr;
    logic                    atomic;
    logic [4:0]              funct5;
    logic [PuWidthNbits-1:0] wdata;
  } io_type;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  function automatic logic [PuMemSelMsb-PuMemSelLsb:0] mem_sel(input io_type cmd);
    return cmd.addr[PuMemSelMsb:PuMemSelLsb];
  endfunction

endpackage

// File: rtl/pu_io_req_router_if.sv
// PU-side command/ack bus and target-side request/ack bus of the router.
// The slave modport is the router; the master modport is the PU plus targets.
interface pu_io_req_router_if
  import pu_io_req_router_pkg::*;
#(
  parameter int unsigned NUM_OF_TGT  = PuNumOfTgt,
  parameter int unsigned WIDTH_NBITS = PuWidthNbits
) ();

  logic                                   pu_io_req;
  io_type                                 pu_io_cmd;
  logic                                   pu_io_full;
  logic                                   pu_io_ack;
  logic [WIDTH_NBITS-1:0]                 pu_io_ack_data;
  logic                                   pu_io_err;
  logic [NUM_OF_TGT-1:0]                  tgt_io_req;
  io_type                                 tgt_io_cmd;
  logic [NUM_OF_TGT-1:0]                  tgt_io_ack;
  logic [NUM_OF_TGT-1:0][WIDTH_NBITS-1:0] tgt_io_ack_data;

  modport slave (
    input  pu_io_req, pu_io_cmd, tgt_io_ack, tgt_io_ack_data,
    output pu_io_full, pu_io_ack, pu_io_ack_data, pu_io_err, tgt_io_req, tgt_io_cmd
  );

  modport master (
    output pu_io_req, pu_io_cmd, tgt_io_ack, tgt_io_ack_data,
    input  pu_io_full, pu_io_ack, pu_io_ack_data, pu_io_err, tgt_io_req, tgt_io_cmd
  );

endinterface

// File: rtl/pu_io_req_router_sfifo2f.sv
// Two-entry synchronous FIFO; pushes while full and pops while empty are dropped.
module pu_io_req_router_sfifo2f #(
  parameter int unsigned DATA_NBITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_NBITS-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_NBITS-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_full
);

  logic [DATA_NBITS-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_cnt;
  logic                  w_push;
  logic                  w_pop;

  assign o_empty = (r_cnt == 2'd0);
  assign o_full  = (r_cnt == 2'd2);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/pu_io_req_router.sv
// Per-PU io front end: buffers commands, routes each to one memory target, waits
// for its ack (or a timeout) and returns the result; one request outstanding.
module pu_io_req_router
  import pu_io_req_router_pkg::*;
#(
  parameter int unsigned NUM_OF_TGT    = PuNumOfTgt,
  parameter int unsigned WIDTH_NBITS   = PuWidthNbits,
  parameter int unsigned TIMEOUT_NBITS = PuIoTimeoutNbits
) (
  input logic                clk,
  input logic                rst_n,
  pu_io_req_router_if.slave  io
);

  localparam int unsigned SelNbits = (NUM_OF_TGT > 1) ? $clog2(NUM_OF_TGT) : 1;
  localparam int unsigned FldNbits = PuMemSelMsb - PuMemSelLsb + 1;
  localparam logic [TIMEOUT_NBITS-1:0] CntMax = '1;

  state_e                      r_state, w_state_d;
  logic                        w_fifo_empty, w_fifo_full;
  logic [$bits(io_type)-1:0]   w_head_raw;
  io_type                      w_head;
  logic [FldNbits-1:0]         w_head_fld;
  logic [SelNbits-1:0]         w_head_idx;
  logic                        w_unmapped, w_head_stale, w_pop, w_issue;
  logic                        w_got_ack, w_timeout;
  logic [NUM_OF_TGT-1:0]       r_stale, w_stale_eff, w_stale_d;
  logic [SelNbits-1:0]         r_sel, w_sel_d;
  logic [TIMEOUT_NBITS-1:0]    r_cnt, w_cnt_d;
  logic [NUM_OF_TGT-1:0]       r_tgt_req, w_tgt_req_d;
  io_type                      r_tgt_cmd;
  logic                        r_ack, w_ack_d, r_err, w_err_d;
  logic [WIDTH_NBITS-1:0]      r_ack_data, w_ack_data_d;

  pu_io_req_router_sfifo2f #(
    .DATA_NBITS ($bits(io_type))
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (io.pu_io_req),
    .i_data  (io.pu_io_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head_raw),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign w_head     = io_type'(w_head_raw);
  assign w_head_fld = mem_sel(w_head);
  assign w_head_idx = w_head_fld[SelNbits-1:0];
  assign w_unmapped = (32'(w_head_fld) >= NUM_OF_TGT);

  // An ack from a stale target clears it in the same cycle, so a held command
  // can issue straight away.
  assign w_stale_eff  = r_stale & ~io.tgt_io_ack;
  assign w_head_stale = w_stale_eff[w_head_idx];

  assign w_pop     = (r_state == StIdle) && !w_fifo_empty && (w_unmapped || !w_head_stale);
  assign w_issue   = w_pop && !w_unmapped;
  assign w_got_ack = (r_state == StWait) && io.tgt_io_ack[r_sel];
  assign w_timeout = (r_state == StWait) && !w_got_ack && (r_cnt == CntMax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_stale    <= '0;
      r_sel      <= '0;
      r_cnt      <= '0;
      r_tgt_req  <= '0;
      r_ack      <= 1'b0;
      r_ack_data <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_stale    <= w_stale_d;
      r_sel      <= w_sel_d;
      r_cnt      <= w_cnt_d;
      r_tgt_req  <= w_tgt_req_d;
      r_ack      <= w_ack_d;
      r_ack_data <= w_ack_data_d;
      r_err      <= w_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) r_tgt_cmd <= w_head;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_pop) w_state_d = w_unmapped ? StResp : StWait;
      StWait:  if (w_got_ack || w_timeout) w_state_d = StIdle;
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_tgt_req_d  = '0;
    w_ack_d      = 1'b0;
    w_ack_data_d = '0;
    w_err_d      = 1'b0;
    w_sel_d      = r_sel;
    w_cnt_d      = r_cnt;
    w_stale_d    = w_stale_eff;
    unique case (r_state)
      StIdle: begin
        if (w_pop && w_unmapped) begin
          w_ack_d = 1'b1;
          w_err_d = 1'b1;
        end else if (w_issue) begin
          w_tgt_req_d[w_head_idx] = 1'b1;
          w_sel_d                 = w_head_idx;
          w_cnt_d                 = '0;
        end
      end
      StWait: begin
        w_cnt_d = r_cnt + 1'b1;
        if (w_got_ack) begin
          w_ack_d      = 1'b1;
          w_ack_data_d = io.tgt_io_ack_data[r_sel];
        end else if (w_timeout) begin
          w_ack_d          = 1'b1;
          w_err_d          = 1'b1;
          w_stale_d[r_sel] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign io.pu_io_full     = w_fifo_full;
  assign io.pu_io_ack      = r_ack;
  assign io.pu_io_ack_data = r_ack_data;
  assign io.pu_io_err      = r_err;
  assign io.tgt_io_req     = r_tgt_req;
  assign io.tgt_io_cmd     = r_tgt_cmd;

endmodule

// File: tb/tb_pu_io_req_router.sv
// Directed bench for pu_io_req_router; expectations are queued by the stimulus and
// checked by a negedge monitor whenever the router issues a request or an ack.
module tb_pu_io_req_router;
  import pu_io_req_router_pkg::*;

  localparam int unsigned NT = 4;
  localparam int unsigned W  = 32;

  typedef struct {
    logic [NT-1:0] req;
    logic [15:0]   addr;
    logic [3:0]    tid;
    int            cyc;
  } req_exp_t;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    int           cyc;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   outstanding = 1'b0;
  req_exp_t req_q[$];
  rsp_exp_t rsp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pu_io_req_router_if #(.NUM_OF_TGT(NT), .WIDTH_NBITS(W)) bus ();

  pu_io_req_router #(
    .NUM_OF_TGT    (NT),
    .WIDTH_NBITS   (W),
    .TIMEOUT_NBITS (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    req_exp_t re;
    rsp_exp_t se;
    if (!rst_n) begin
      outstanding <= 1'b0;
    end else begin
      check("illegal_push", 64'(bus.pu_io_req & bus.pu_io_full), 64'd0);
      if (bus.tgt_io_req != '0) begin
        check("req_while_busy", 64'(outstanding), 64'd0);
        outstanding <= 1'b1;
        if (req_q.size() == 0) begin
          check("unexpected_req", 64'(bus.tgt_io_req), 64'd0);
        end else begin
          re = req_q.pop_front();
          check("req_onehot", 64'(bus.tgt_io_req), 64'(re.req));
          check("req_addr", 64'(bus.tgt_io_cmd.addr), 64'(re.addr));
          check("req_tid", 64'(bus.tgt_io_cmd.tid), 64'(re.tid));
          check("req_cycle", 64'(cyc), 64'(re.cyc));
        end
      end
      if (bus.pu_io_ack) begin
        outstanding <= 1'b0;
        if (rsp_q.size() == 0) begin
          check("unexpected_ack", 64'(bus.pu_io_ack), 64'd0);
        end else begin
          se = rsp_q.pop_front();
          check("ack_data", 64'(bus.pu_io_ack_data), 64'(se.data));
          check("ack_err", 64'(bus.pu_io_err), 64'(se.err));
          check("ack_cycle", 64'(cyc), 64'(se.cyc));
        end
      end else begin
        check("idle_ack_data", 64'(bus.pu_io_ack_data), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input logic [2:0] sel, input logic [12:0] off, input logic [3:0] tid,
                      input logic wr);
    io_type c;
    c        = '0;
    c.addr   = {sel, off};
    c.tid    = tid;
    c.wr     = wr;
    c.wdata  = {19'h0, off};
    bus.pu_io_cmd = c;
    bus.pu_io_req = 1'b1;
    tick();
    bus.pu_io_req = 1'b0;
  endtask

  task automatic wait_req(output int rc);
    rc = -1;
    for (int i = 0; i < 400; i++) begin
      if (bus.tgt_io_req != '0) begin
        rc = cyc;
        break;
      end
      tick();
    end
    if (rc < 0) check("wait_req_bound", 64'd0, 64'd1);
  endtask

  task automatic ack(input int t, input logic [W-1:0] d);
    bus.tgt_io_ack         = '0;
    bus.tgt_io_ack[t]      = 1'b1;
    bus.tgt_io_ack_data[t] = d;
    tick();
    bus.tgt_io_ack      = '0;
    bus.tgt_io_ack_data = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_full"}, 64'(bus.pu_io_full), 64'd0);
    check({tag, "_ack"}, 64'(bus.pu_io_ack), 64'd0);
    check({tag, "_ack_data"}, 64'(bus.pu_io_ack_data), 64'd0);
    check({tag, "_err"}, 64'(bus.pu_io_err), 64'd0);
    check({tag, "_tgt_req"}, 64'(bus.tgt_io_req), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    bus.pu_io_req       = 1'b0;
    bus.pu_io_cmd       = '0;
    bus.tgt_io_ack      = '0;
    bus.tgt_io_ack_data = '0;
    idle(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Read to target 0, acked three cycles after the request.
    req_q.push_back('{4'b0001, 16'h0005, 4'd3, cyc + 2});
    push(3'd0, 13'd5, 4'd3, 1'b0);
    wait_req(c);
    idle(3);
    rsp_q.push_back('{32'h1234, 1'b0, cyc + 1});
    ack(0, 32'h1234);
    idle(3);

    // Back-to-back commands to targets 1 and 2; second waits for the first ack.
    req_q.push_back('{4'b0010, {3'd1, 13'h10}, 4'd1, cyc + 2});
    push(3'd1, 13'h10, 4'd1, 1'b1);
    check("full_after_1st_push", 64'(bus.pu_io_full), 64'd0);
    push(3'd2, 13'h20, 4'd2, 1'b0);
    check("full_push_pop", 64'(bus.pu_io_full), 64'd0);
    wait_req(c);
    idle(2);
    rsp_q.push_back('{32'hA1, 1'b0, cyc + 1});
    req_q.push_back('{4'b0100, {3'd2, 13'h20}, 4'd2, cyc + 2});
    ack(1, 32'hA1);
    wait_req(c);
    idle(1);
    rsp_q.push_back('{32'hB2, 1'b0, cyc + 1});
    ack(2, 32'hB2);
    idle(3);

    // Unmapped target: error response, no target request.
    rsp_q.push_back('{32'h0, 1'b1, cyc + 2});
    push(3'd5, 13'h7, 4'd5, 1'b0);
    idle(4);

    // Target 3 never acks: timeout, then a stalled command released by a late ack.
    req_q.push_back('{4'b1000, {3'd3, 13'h30}, 4'd6, cyc + 2});
    push(3'd3, 13'h30, 4'd6, 1'b0);
    wait_req(c);
    rsp_q.push_back('{32'h0, 1'b1, c + 256});
    idle(257);
    push(3'd3, 13'h31, 4'd7, 1'b0);
    idle(6);
    check("stall_not_full", 64'(bus.pu_io_full), 64'd0);
    check("stall_no_req", 64'(bus.tgt_io_req), 64'd0);
    req_q.push_back('{4'b1000, {3'd3, 13'h31}, 4'd7, cyc + 1});
    ack(3, 32'h5555);
    wait_req(c);
    idle(1);
    rsp_q.push_back('{32'h33, 1'b0, cyc + 1});
    ack(3, 32'h33);
    idle(3);

    // Ack lands in the exact timeout cycle: ack wins, target stays usable.
    req_q.push_back('{4'b0001, {3'd0, 13'h40}, 4'd8, cyc + 2});
    push(3'd0, 13'h40, 4'd8, 1'b0);
    wait_req(c);
    idle(255);
    rsp_q.push_back('{32'hBEEF, 1'b0, cyc + 1});
    ack(0, 32'hBEEF);
    idle(2);
    req_q.push_back('{4'b0001, {3'd0, 13'h41}, 4'd9, cyc + 2});
    push(3'd0, 13'h41, 4'd9, 1'b0);
    wait_req(c);
    idle(1);
    rsp_q.push_back('{32'h77, 1'b0, cyc + 1});
    ack(0, 32'h77);
    idle(3);

    // Reset while waiting; stray acks afterwards must produce nothing.
    req_q.push_back('{4'b0010, {3'd1, 13'h50}, 4'd10, cyc + 2});
    push(3'd1, 13'h50, 4'd10, 1'b0);
    wait_req(c);
    idle(5);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_wait_reset");
    idle(2);
    rst_n = 1'b1;
    idle(1);
    ack(0, 32'hDEAD);
    ack(1, 32'hCAFE);
    idle(4);
    check_outputs_zero("after_stray_ack");

    check("req_q_drained", 64'(req_q.size()), 64'd0);
    check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
